// File: rtl/hazard_control.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes,
// EX operand forwarding select and saturating stall/flush statistics.
module hazard_control #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_WIDTH         = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           rs1_id,
  input  logic [4:0]           rs2_id,
  input  logic                 uses_rs1_id,
  input  logic                 uses_rs2_id,
  input  logic [4:0]           rs1_ex,
  input  logic [4:0]           rs2_ex,
  input  logic [4:0]           rd_ex,
  input  logic                 RUWr_ex,
  input  logic [1:0]           RUDataWrSrc_ex,
  input  logic                 branch_taken_ex,
  input  logic [4:0]           rd_mem,
  input  logic                 RUWr_mem,
  input  logic [4:0]           rd_wb,
  input  logic                 RUWr_wb,
  output logic                 pc_stall,
  output logic                 fd_stall,
  output logic                 fd_flush,
  output logic                 de_flush,
  output logic [1:0]           fwd_a_sel,
  output logic [1:0]           fwd_b_sel,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int unsigned CW = 3;
  localparam logic [CW-1:0] STALL_RELOAD = CW'(LOAD_STALL_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [1:0] SRC_DMEM = 2'b01;
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {RUN, STALL} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            load_use;
  logic            flush_evt;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    load_use = RUWr_ex && (RUDataWrSrc_ex == SRC_DMEM) && (rd_ex != 5'd0) &&
               ((uses_rs1_id && (rs1_id == rd_ex)) || (uses_rs2_id && (rs2_id == rd_ex)));
  end

  // State and bubble down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and Mealy stall/flush controls; branch flush beats stall.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_stall  = 1'b0;
    fd_stall  = 1'b0;
    fd_flush  = 1'b0;
    de_flush  = 1'b0;
    flush_evt = 1'b0;
    if (!rst_n) begin
      fd_flush = 1'b1;
      de_flush = 1'b1;
      state_d  = RUN;
      cnt_d    = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken_ex) begin
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            flush_evt = 1'b1;
          end else if (load_use) begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              state_d = STALL;
              cnt_d   = STALL_RELOAD;
            end
          end
        end
        STALL: begin
          if (branch_taken_ex) begin
            fd_flush  = 1'b1;
            de_flush  = 1'b1;
            flush_evt = 1'b1;
            state_d   = RUN;
            cnt_d     = '0;
          end else begin
            pc_stall = 1'b1;
            fd_stall = 1'b1;
            de_flush = 1'b1;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) begin
              state_d = RUN;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Operand forwarding; the younger MEM result wins over WB, x0 never forwarded.
  always_comb begin
    fwd_a_sel = FWD_RF;
    fwd_b_sel = FWD_RF;
    if (rst_n) begin
      if (RUWr_mem && (rd_mem != 5'd0) && (rd_mem == rs1_ex))     fwd_a_sel = FWD_MEM;
      else if (RUWr_wb && (rd_wb != 5'd0) && (rd_wb == rs1_ex))   fwd_a_sel = FWD_WB;
      if (RUWr_mem && (rd_mem != 5'd0) && (rd_mem == rs2_ex))     fwd_b_sel = FWD_MEM;
      else if (RUWr_wb && (rd_wb != 5'd0) && (rd_wb == rs2_ex))   fwd_b_sel = FWD_WB;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_stall && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_WIDTH'(1);
      if (flush_evt && (flush_count != CNT_MAX)) flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Directed self-checking bench for hazard_control across several parameter sets.
module tb_hazard_control;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic uses_rs1_id, uses_rs2_id, RUWr_ex, branch_taken_ex, RUWr_mem, RUWr_wb;
  logic [1:0] RUDataWrSrc_ex;

  logic d_pc, d_fds, d_fdf, d_def;   logic [1:0] d_fa, d_fb;   logic [15:0] d_sc, d_fc;
  logic s3_pc, s3_fds, s3_fdf, s3_def; logic [1:0] s3_fa, s3_fb; logic [15:0] s3_sc, s3_fc;
  logic s4_pc, s4_fds, s4_fdf, s4_def; logic [1:0] s4_fa, s4_fb; logic [15:0] s4_sc, s4_fc;
  logic c4_pc, c4_fds, c4_fdf, c4_def; logic [1:0] c4_fa, c4_fb; logic [3:0]  c4_sc, c4_fc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_control u_d (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id),
    .uses_rs2_id(uses_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RUWr_ex(RUWr_ex),
    .RUDataWrSrc_ex(RUDataWrSrc_ex), .branch_taken_ex(branch_taken_ex), .rd_mem(rd_mem),
    .RUWr_mem(RUWr_mem), .rd_wb(rd_wb), .RUWr_wb(RUWr_wb), .pc_stall(d_pc), .fd_stall(d_fds),
    .fd_flush(d_fdf), .de_flush(d_def), .fwd_a_sel(d_fa), .fwd_b_sel(d_fb),
    .stall_count(d_sc), .flush_count(d_fc));

  hazard_control #(.LOAD_STALL_CYCLES(3)) u_s3 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id),
    .uses_rs2_id(uses_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RUWr_ex(RUWr_ex),
    .RUDataWrSrc_ex(RUDataWrSrc_ex), .branch_taken_ex(branch_taken_ex), .rd_mem(rd_mem),
    .RUWr_mem(RUWr_mem), .rd_wb(rd_wb), .RUWr_wb(RUWr_wb), .pc_stall(s3_pc), .fd_stall(s3_fds),
    .fd_flush(s3_fdf), .de_flush(s3_def), .fwd_a_sel(s3_fa), .fwd_b_sel(s3_fb),
    .stall_count(s3_sc), .flush_count(s3_fc));

  hazard_control #(.LOAD_STALL_CYCLES(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id),
    .uses_rs2_id(uses_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RUWr_ex(RUWr_ex),
    .RUDataWrSrc_ex(RUDataWrSrc_ex), .branch_taken_ex(branch_taken_ex), .rd_mem(rd_mem),
    .RUWr_mem(RUWr_mem), .rd_wb(rd_wb), .RUWr_wb(RUWr_wb), .pc_stall(s4_pc), .fd_stall(s4_fds),
    .fd_flush(s4_fdf), .de_flush(s4_def), .fwd_a_sel(s4_fa), .fwd_b_sel(s4_fb),
    .stall_count(s4_sc), .flush_count(s4_fc));

  hazard_control #(.CNT_WIDTH(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .rs1_id(rs1_id), .rs2_id(rs2_id), .uses_rs1_id(uses_rs1_id),
    .uses_rs2_id(uses_rs2_id), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex), .RUWr_ex(RUWr_ex),
    .RUDataWrSrc_ex(RUDataWrSrc_ex), .branch_taken_ex(branch_taken_ex), .rd_mem(rd_mem),
    .RUWr_mem(RUWr_mem), .rd_wb(rd_wb), .RUWr_wb(RUWr_wb), .pc_stall(c4_pc), .fd_stall(c4_fds),
    .fd_flush(c4_fdf), .de_flush(c4_def), .fwd_a_sel(c4_fa), .fwd_b_sel(c4_fb),
    .stall_count(c4_sc), .flush_count(c4_fc));

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0;
    uses_rs1_id = 1'b0; uses_rs2_id = 1'b0; RUWr_ex = 1'b0; branch_taken_ex = 1'b0;
    RUWr_mem = 1'b0; RUWr_wb = 1'b0; RUDataWrSrc_ex = 2'b00;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1);
    RUWr_ex = 1'b1; RUDataWrSrc_ex = 2'b01; rd_ex = rd; rs1_id = rs1; uses_rs1_id = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    tick();
    // reset state, with a would-be forward present to show it is suppressed
    RUWr_mem = 1'b1; rd_mem = 5'd7; rs1_ex = 5'd7;
    #1;
    chk("rst_fd_flush", 32'(d_fdf), 32'd1);
    chk("rst_de_flush", 32'(d_def), 32'd1);
    chk("rst_pc_stall", 32'(d_pc), 32'd0);
    chk("rst_fd_stall", 32'(d_fds), 32'd0);
    chk("rst_fwd_a", 32'(d_fa), 32'd0);
    chk("rst_stall_count", 32'(d_sc), 32'd0);
    chk("rst_flush_count", 32'(d_fc), 32'd0);

    // 1: single-cycle load-use bubble
    do_reset();
    set_load(5'd5, 5'd5);
    #1;
    chk("t1_pc_stall", 32'(d_pc), 32'd1);
    chk("t1_fd_stall", 32'(d_fds), 32'd1);
    chk("t1_de_flush", 32'(d_def), 32'd1);
    chk("t1_fd_flush", 32'(d_fdf), 32'd0);
    tick();
    RUWr_ex = 1'b0;
    #1;
    chk("t1_pc_stall_after", 32'(d_pc), 32'd0);
    chk("t1_de_flush_after", 32'(d_def), 32'd0);
    chk("t1_stall_count", 32'(d_sc), 32'd1);

    // 2: multi-cycle bubble continues from FSM state once the hazard is gone
    do_reset();
    set_load(5'd5, 5'd5);
    #1;
    chk("t2_s3_cyc1", 32'(s3_pc), 32'd1);
    tick();
    #1;
    chk("t2_s3_cyc2", 32'(s3_pc), 32'd1);
    tick();
    RUWr_ex = 1'b0;
    #1;
    chk("t2_s3_cyc3", 32'(s3_pc), 32'd1);
    chk("t2_d_cyc3", 32'(d_pc), 32'd0);
    tick();
    #1;
    chk("t2_s3_cyc4", 32'(s3_pc), 32'd0);
    chk("t2_s3_stall_count", 32'(s3_sc), 32'd3);
    chk("t2_s4_cyc4", 32'(s4_pc), 32'd1);
    chk("t2_d_stall_count", 32'(d_sc), 32'd2);
    tick();
    #1;
    chk("t2_s4_cyc5", 32'(s4_pc), 32'd0);
    chk("t2_s4_stall_count", 32'(s4_sc), 32'd4);

    // 3: branch beats load-use in the same cycle
    do_reset();
    set_load(5'd5, 5'd5);
    branch_taken_ex = 1'b1;
    #1;
    chk("t3_fd_flush", 32'(d_fdf), 32'd1);
    chk("t3_de_flush", 32'(d_def), 32'd1);
    chk("t3_pc_stall", 32'(d_pc), 32'd0);
    chk("t3_fd_stall", 32'(d_fds), 32'd0);
    tick();
    clear_inputs();
    #1;
    chk("t3_flush_count", 32'(d_fc), 32'd1);
    chk("t3_stall_count", 32'(d_sc), 32'd0);

    // 3b: branch arriving mid-STALL aborts the bubble
    do_reset();
    set_load(5'd5, 5'd5);
    tick();
    RUWr_ex = 1'b0;
    branch_taken_ex = 1'b1;
    #1;
    chk("t3b_pc_stall", 32'(s4_pc), 32'd0);
    chk("t3b_fd_flush", 32'(s4_fdf), 32'd1);
    tick();
    branch_taken_ex = 1'b0;
    #1;
    chk("t3b_pc_after", 32'(s4_pc), 32'd0);
    chk("t3b_flush_count", 32'(s4_fc), 32'd1);
    chk("t3b_stall_count", 32'(s4_sc), 32'd1);

    // 4: x0 never stalls; forwarding priority
    do_reset();
    set_load(5'd0, 5'd0);
    RUWr_mem = 1'b1; rd_mem = 5'd7; RUWr_wb = 1'b1; rd_wb = 5'd7; rs1_ex = 5'd7; rs2_ex = 5'd3;
    #1;
    chk("t4_x0_no_stall", 32'(d_pc), 32'd0);
    chk("t4_fwd_a_mem", 32'(d_fa), 32'd2);
    chk("t4_fwd_b_none", 32'(d_fb), 32'd0);
    RUWr_mem = 1'b0;
    #1;
    chk("t4_fwd_a_wb", 32'(d_fa), 32'd1);
    rs2_ex = 5'd7;
    #1;
    chk("t4_fwd_b_wb", 32'(d_fb), 32'd1);
    RUWr_mem = 1'b1; rd_mem = 5'd0; rd_wb = 5'd0; rs1_ex = 5'd0;
    #1;
    chk("t4_fwd_a_x0", 32'(d_fa), 32'd0);
    rd_ex = 5'd9; rs2_id = 5'd9; uses_rs2_id = 1'b1; uses_rs1_id = 1'b0;
    #1;
    chk("t4_rs2_stall", 32'(d_pc), 32'd1);
    uses_rs2_id = 1'b0;
    #1;
    chk("t4_rs2_unused", 32'(d_pc), 32'd0);

    // 5: reset in the middle of a long bubble
    do_reset();
    set_load(5'd5, 5'd5);
    tick();
    #1;
    chk("t5_stall_cyc2", 32'(s4_pc), 32'd1);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    chk("t5_rst_fd_flush", 32'(s4_fdf), 32'd1);
    chk("t5_rst_de_flush", 32'(s4_def), 32'd1);
    chk("t5_rst_pc_stall", 32'(s4_pc), 32'd0);
    chk("t5_rst_stall_count", 32'(s4_sc), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("t5_post_pc_stall", 32'(s4_pc), 32'd0);
    chk("t5_post_fd_stall", 32'(s4_fds), 32'd0);
    chk("t5_post_fd_flush", 32'(s4_fdf), 32'd0);
    chk("t5_post_de_flush", 32'(s4_def), 32'd0);

    // 6: 20 taken branches saturate a 4-bit counter
    do_reset();
    branch_taken_ex = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    branch_taken_ex = 1'b0;
    #1;
    chk("t6_c4_flush_sat", 32'(c4_fc), 32'd15);
    chk("t6_d_flush_count", 32'(d_fc), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
